// File: rtl/module_serial_alu_pkg.sv
// Shared encodings for the serial ALU: op codes, slice selects and FSM states.
// Imported by the RTL and by the bench so both agree on every code.
package module_serial_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_is_legal = 1'b1;
            default:                               op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        op_is_arith = (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/module_serial_alu_slice.sv
// Combinational SLICE-bit ripple of 1-bit ALU cells (AND/OR/ADD/LESS with optional B invert).
// Also exposes the carry into the slice MSB so the top can derive overflow.
module module_alu_slice
    import module_serial_alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    input  logic [2:0]       i_aluop,
    input  logic             i_less,
    output logic [SLICE-1:0] o_r,
    output logic             o_cout,
    output logic             o_cin_msb
);

    logic [SLICE:0]   w_c;
    logic [SLICE-1:0] w_bb;

    // Per-bit cells; carry ripples from bit 0 upward
    always_comb begin
        w_c    = '0;
        w_bb   = '0;
        o_r    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SLICE; i++) begin
            w_bb[i]    = i_b[i] ^ i_aluop[2];
            w_c[i + 1] = (i_a[i] & w_bb[i]) | (i_a[i] & w_c[i]) | (w_bb[i] & w_c[i]);
            case (i_aluop[1:0])
                SEL_AND:  o_r[i] = i_a[i] & w_bb[i];
                SEL_OR:   o_r[i] = i_a[i] | w_bb[i];
                SEL_ADD:  o_r[i] = i_a[i] ^ w_bb[i] ^ w_c[i];
                SEL_LESS: o_r[i] = (i == 0) ? i_less : 1'b0;
                default:  o_r[i] = 1'b0;
            endcase
        end
    end

    assign o_cout    = w_c[SLICE];
    assign o_cin_msb = w_c[SLICE-1];

endmodule

// File: rtl/module_serial_alu.sv
// Serial ALU: processes SLICE bits per clock through one module_alu_slice, WIDTH/SLICE cycles per op.
// Results and flags are registered and held from one done pulse to the next.
module module_serial_alu
    import module_serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_result, w_full;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_zero, r_cout, r_ovf, r_busy, r_done;
    logic [SLICE-1:0] w_r;
    logic             w_cout, w_cin_msb, w_load, w_last, w_set;

    assign w_load = start && (r_state != ST_RUN);
    assign w_last = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
    // Sign of (a-b) corrected by its overflow; only meaningful on the final slice
    assign w_set  = (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ r_op[2] ^ w_cin_msb) ^ (w_cin_msb ^ w_cout);

    module_alu_slice #(.SLICE(SLICE)) u_slice (
        .i_a       (r_a[r_cnt*SLICE +: SLICE]),
        .i_b       (r_b[r_cnt*SLICE +: SLICE]),
        .i_cin     (r_carry),
        .i_aluop   (r_op),
        .i_less    (1'b0),
        .o_r       (w_r),
        .o_cout    (w_cout),
        .o_cin_msb (w_cin_msb)
    );

    // Final result image: accumulated slices plus the last one; SLT patches bit 0
    always_comb begin
        w_full = '0;
        case (r_op)
            OP_SLT: w_full = {{(WIDTH-1){1'b0}}, w_set};
            OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                w_full = r_acc;
                w_full[(N-1)*SLICE +: SLICE] = w_r;
            end
            default: w_full = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = start  ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_next = start  ? ST_RUN  : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, slice stepping, result and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0; r_b <= '0; r_op <= 3'b000; r_acc <= '0;
            r_cnt <= '0; r_carry <= 1'b0; r_result <= '0;
            r_zero <= 1'b0; r_cout <= 1'b0; r_ovf <= 1'b0;
            r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_RUN);
            r_done <= w_last;
            if (w_load) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= aluop;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_carry <= aluop[2];
            end else if (r_state == ST_RUN) begin
                r_acc[r_cnt*SLICE +: SLICE] <= w_r;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CNT_ONE;
                if (w_last) begin
                    r_result <= w_full;
                    r_zero   <= op_is_legal(r_op) && (w_full == '0);
                    r_cout   <= op_is_arith(r_op) & w_cout;
                    r_ovf    <= op_is_arith(r_op) & (w_cin_msb ^ w_cout);
                end
            end
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
